// File: rtl/l1_dcache_pkg.sv
// l1_dcache_pkg: package Cache holding the shared FSM state enum and memory-bus beat type
package Cache;
   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;
   typedef struct packed {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } mem_beat_t;
endpackage

// File: rtl/l1dcache_core_if.sv
// l1dcache_core_if: core-side request/response bundle of the L1 data cache
interface l1dcache_core_if;
   logic        en;
   logic        enW;
   logic [29:0] addr;
   logic [3:0]  mask;
   logic [31:0] reqData;
   logic [31:0] respData;
   logic        nack;
   modport Server(input en, enW, addr, mask, reqData, output respData, nack);
   modport Client(output en, enW, addr, mask, reqData, input respData, nack);
endinterface

// File: rtl/l1_dcache_data_ram.sv
// dcache_data_ram: tag/valid/data storage, combinational read port, byte-masked write port
module dcache_data_ram #(
   parameter int NUM_LINES  = 64,
   parameter int LINE_WORDS = 4,
   parameter int TAG_W      = 22
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [$clog2(NUM_LINES)-1:0]  rd_idx_i,
   input  logic [$clog2(LINE_WORDS)-1:0] rd_off_i,
   output logic [31:0]                   rd_data_o,
   output logic [TAG_W-1:0]              rd_tag_o,
   output logic                          rd_valid_o,
   input  logic                          wr_en_i,
   input  logic [$clog2(NUM_LINES)-1:0]  wr_idx_i,
   input  logic [$clog2(LINE_WORDS)-1:0] wr_off_i,
   input  logic [3:0]                    wr_mask_i,
   input  logic [31:0]                   wr_data_i,
   input  logic                          tag_we_i,
   input  logic                          tag_valid_i,
   input  logic [TAG_W-1:0]              tag_i
);
   logic [31:0]      data_q [NUM_LINES*LINE_WORDS];
   logic [TAG_W-1:0] tag_q [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;
   assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_valid_o = valid_q[rd_idx_i];
   // byte-masked data word write
   always_ff @(posedge clk) begin
      if (wr_en_i)
         for (int b = 0; b < 4; b++)
            if (wr_mask_i[b]) data_q[{wr_idx_i, wr_off_i}][8*b +: 8] <= wr_data_i[8*b +: 8];
   end
   // tag write, no reset needed since valid guards it
   always_ff @(posedge clk) begin
      if (tag_we_i) tag_q[wr_idx_i] <= tag_i;
   end
   // valid bits, all cleared on reset
   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else if (tag_we_i) valid_q[wr_idx_i] <= tag_valid_i;
   end
endmodule

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped write-through no-allocate L1 data cache; L1DCACHE_PERF_EN adds hit/miss counters
module l1_dcache
   import Cache::*;
#(
   parameter int NUM_LINES  = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   l1dcache_core_if.Server core,
   output logic        memReq,
   output logic        memWe,
   output logic [29:0] memAddr,
   output logic [3:0]  memMask,
   output logic [31:0] memWData,
   input  logic        memAck,
   input  logic [31:0] memRData
`ifdef L1DCACHE_PERF_EN
   ,
   output logic [31:0] hitCnt,
   output logic [31:0] missCnt
`endif
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
   state_e                state_q, state_d;
   logic [29-OFF_W:0]     base_q, base_d;
   logic [OFF_W-1:0]      cnt_q, cnt_d;
   mem_beat_t             beat_q, beat_d;
   logic [31:0]           resp_q, resp_d;
   logic                  nack_q, nack_d;
   logic [31:0]           rd_data;
   logic [TAG_W-1:0]      rd_tag;
   logic                  rd_valid, hit, last;
   logic [29:0]           wr_line;
   logic [3:0]            wr_mask;
   logic [31:0]           wr_data;
   logic                  wr_en, tag_we, tag_valid;
   assign hit  = rd_valid && rd_tag == core.addr[29 -: TAG_W];
   assign last = cnt_q == OFF_W'(LINE_WORDS - 1);
   dcache_data_ram #(.NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_ram (
      .clk(clk),
      .rst(rst),
      .rd_idx_i(core.addr[OFF_W +: IDX_W]),
      .rd_off_i(core.addr[OFF_W-1:0]),
      .rd_data_o(rd_data),
      .rd_tag_o(rd_tag),
      .rd_valid_o(rd_valid),
      .wr_en_i(wr_en && !rst),
      .wr_idx_i(wr_line[OFF_W +: IDX_W]),
      .wr_off_i(wr_line[OFF_W-1:0]),
      .wr_mask_i(wr_mask),
      .wr_data_i(wr_data),
      .tag_we_i(tag_we && !rst),
      .tag_valid_i(tag_valid),
      .tag_i(wr_line[29 -: TAG_W])
   );
   assign memReq         = state_q != IDLE;
   assign memWe          = state_q == WRITE && beat_q.we;
   assign memAddr        = memWe ? beat_q.addr : {base_q, cnt_q};
   assign memMask        = memWe ? beat_q.mask : 4'h0;
   assign memWData       = beat_q.wdata;
   assign core.respData  = resp_q;
   assign core.nack      = nack_q;
   // next state, storage writes and registered response; busy states nack every request
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      beat_d    = beat_q;
      resp_d    = resp_q;
      nack_d    = core.en && state_q != IDLE;
      wr_line   = core.addr;
      wr_mask   = core.mask;
      wr_data   = core.reqData;
      wr_en     = 1'b0;
      tag_we    = 1'b0;
      tag_valid = 1'b0;
      case (state_q)
         IDLE:
            if (core.en && !core.enW) begin
               if (hit) resp_d = rd_data;
               else begin
                  nack_d  = 1'b1;
                  base_d  = core.addr[29:OFF_W];
                  tag_we  = 1'b1;
                  cnt_d   = '0;
                  state_d = REFILL;
               end
            end else if (core.en && core.mask != 4'h0) begin
               wr_en   = hit;
               beat_d  = mem_beat_t'{1'b1, core.addr, core.mask, core.reqData};
               state_d = WRITE;
            end
         REFILL: begin
            wr_line = {base_q, cnt_q};
            wr_mask = 4'hf;
            wr_data = memRData;
            wr_en   = memAck;
            if (memAck) begin
               cnt_d     = cnt_q + OFF_W'(1);
               tag_we    = last;
               tag_valid = 1'b1;
               state_d   = last ? IDLE : REFILL;
            end
         end
         WRITE: state_d = memAck ? IDLE : WRITE;
         default: state_d = IDLE;
      endcase
   end
   // state registers; reset abandons any bus transfer in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         beat_q  <= '0;
         resp_q  <= '0;
         nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         resp_q  <= resp_d;
         nack_q  <= nack_d;
      end
   end
`ifdef L1DCACHE_PERF_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   // count loads accepted in IDLE, split by hit/miss, wrapping naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == IDLE && core.en && !core.enW) begin
         hit_cnt_q  <= hit_cnt_q + {31'd0, hit};
         miss_cnt_q <= miss_cnt_q + {31'd0, !hit};
      end
   end
   assign hitCnt  = hit_cnt_q;
   assign missCnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: scoreboard bench for l1_dcache with a stalling backing-memory responder
module tb_l1_dcache;
   typedef struct {
      logic        nack;
      logic [31:0] data;
      bit          cd;
      int          due;
   } exp_t;
   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } beat_t;
   logic        clk = 1'b0;
   logic        rst;
   logic        memReq, memWe, memAck;
   logic [29:0] memAddr, held;
   logic [3:0]  memMask;
   logic [31:0] memWData, memRData, last_data, merged;
`ifdef L1DCACHE_PERF_EN
   logic [31:0] hitCnt, missCnt;
`endif
   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int stall = 0;
   int wcnt = 0;
   exp_t  q[$];
   beat_t obs[$];
   l1dcache_core_if cif();
   l1_dcache dut (
      .clk(clk),
      .rst(rst),
      .core(cif),
      .memReq(memReq),
      .memWe(memWe),
      .memAddr(memAddr),
      .memMask(memMask),
      .memWData(memWData),
      .memAck(memAck),
      .memRData(memRData)
`ifdef L1DCACHE_PERF_EN
      ,
      .hitCnt(hitCnt),
      .missCnt(missCnt)
`endif
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [31:0] memfn(input logic [29:0] a);
      return {a[7:0] ^ 8'h5A, a[7:0], ~a[7:0], a[7:0] + 8'h11};
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic issue(input logic e, input logic w, input logic [29:0] a, input logic [3:0] m,
                        input logic [31:0] d, input logic en_n, input logic [31:0] ed, input bit cd);
      cif.en = e;
      cif.enW = w;
      cif.addr = a;
      cif.mask = m;
      cif.reqData = d;
      @(posedge clk);
      #1;
      q.push_back(exp_t'{en_n, ed, cd, cyc});
      cif.en = 1'b0;
      cif.enW = 1'b0;
   endtask
   task automatic load(input logic [29:0] a, input logic en_n, input logic [31:0] ed, input bit cd);
      issue(1'b1, 1'b0, a, 4'h0, 32'h0, en_n, ed, cd);
      if (cd) last_data = ed;
   endtask
   task automatic store(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
      issue(1'b1, 1'b1, a, m, d, 1'b0, 32'h0, 1'b0);
   endtask
   task automatic wait_beats(input int n);
      int k = 0;
      while (obs.size() < n && k < 300) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("beat_wait", 32'(obs.size() >= n), 32'd1);
   endtask
   task automatic wait_idle();
      int k = 0;
      while (memReq && k < 300) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("idle_wait", 32'(memReq), 32'd0);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("nack", 32'(cif.nack), 32'(e.nack));
            if (e.cd) check("resp", cif.respData, e.data);
         end
      end
   end
   initial begin
      memAck = 1'b0;
      memRData = '0;
      forever begin
         @(negedge clk);
         if (memAck) begin
            memAck = 1'b0;
            wcnt = 0;
         end else if (memReq && !rst) begin
            if (wcnt > 0) check("addr_stable", 32'(memAddr), 32'(held));
            else held = memAddr;
            if (wcnt >= stall) begin
               memAck = 1'b1;
               memRData = memWe ? 32'h0 : memfn(memAddr);
               obs.push_back(beat_t'{memWe, memAddr, memMask, memWData});
            end else wcnt++;
         end else wcnt = 0;
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end
   initial begin
      rst = 1'b1;
      cif.en = 1'b0;
      cif.enW = 1'b0;
      cif.addr = '0;
      cif.mask = '0;
      cif.reqData = '0;
      last_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_nack", 32'(cif.nack), 32'd0);
      check("rst_resp", cif.respData, 32'd0);
      check("rst_memreq", 32'(memReq), 32'd0);
      obs.delete();
      load(30'h10, 1'b1, 32'h0, 1'b0);
      wait_beats(4);
      for (int i = 0; i < 4; i++) begin
         check("rf_addr", 32'(obs[i].addr), 32'h10 + 32'(i));
         check("rf_we", 32'(obs[i].we), 32'd0);
      end
      wait_idle();
      load(30'h10, 1'b0, memfn(30'h10), 1'b1);
      load(30'h13, 1'b0, memfn(30'h13), 1'b1);
      issue(1'b0, 1'b1, 30'h10, 4'hf, 32'h0, 1'b0, last_data, 1'b1);
      obs.delete();
      store(30'h11, 4'b0100, 32'hAABBCCDD);
      wait_beats(1);
      check("st_we", 32'(obs[0].we), 32'd1);
      check("st_addr", 32'(obs[0].addr), 32'h11);
      check("st_mask", 32'(obs[0].mask), 32'h4);
      check("st_wdata", obs[0].wdata, 32'hAABBCCDD);
      wait_idle();
      merged = (memfn(30'h11) & 32'hFF00FFFF) | 32'h00BB0000;
      load(30'h11, 1'b0, merged, 1'b1);
      obs.delete();
      store(30'h10, 4'h0, 32'hFFFFFFFF);
      repeat (3) @(posedge clk);
      #1;
      check("m0_beats", 32'(obs.size()), 32'd0);
      load(30'h10, 1'b0, memfn(30'h10), 1'b1);
      obs.delete();
      store(30'h200, 4'hf, 32'h12345678);
      wait_beats(1);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      check("nalloc_beats", 32'(obs.size()), 32'd1);
      check("nalloc_addr", 32'(obs[0].addr), 32'h200);
      load(30'h200, 1'b1, 32'h0, 1'b0);
      wait_beats(5);
      check("nalloc_rf", 32'(obs[1].addr), 32'h200);
      wait_idle();
      stall = 3;
      obs.delete();
      load(30'h40, 1'b1, 32'h0, 1'b0);
      load(30'h10, 1'b1, 32'h0, 1'b0);
      wait_beats(4);
      load(30'h10, 1'b1, 32'h0, 1'b0);
      wait_idle();
      check("st_rf_last", 32'(obs[3].addr), 32'h43);
      load(30'h40, 1'b0, memfn(30'h40), 1'b1);
      load(30'h10, 1'b0, memfn(30'h10), 1'b1);
      stall = 1;
      obs.delete();
      load(30'h80, 1'b1, 32'h0, 1'b0);
      wait_beats(2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rrst_memreq", 32'(memReq), 32'd0);
      check("rrst_resp", cif.respData, 32'd0);
      rst = 1'b0;
      obs.delete();
      load(30'h80, 1'b1, 32'h0, 1'b0);
      wait_beats(4);
      check("rrst_rf0", 32'(obs[0].addr), 32'h80);
      wait_idle();
      load(30'h80, 1'b0, memfn(30'h80), 1'b1);
`ifdef L1DCACHE_PERF_EN
      stall = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("perf_rst_hit", hitCnt, 32'd0);
      check("perf_rst_miss", missCnt, 32'd0);
      obs.delete();
      load(30'h10, 1'b1, 32'h0, 1'b0);
      wait_beats(4);
      wait_idle();
      for (int i = 0; i < 3; i++) load(30'h10 + 30'(i), 1'b0, memfn(30'h10 + 30'(i)), 1'b1);
      check("perf_hit", hitCnt, 32'd3);
      check("perf_miss", missCnt, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("perf_clr_hit", hitCnt, 32'd0);
      check("perf_clr_miss", missCnt, 32'd0);
`endif
      repeat (3) @(posedge clk);
      #1;
      check("q_empty", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/l1_dcache.md
L1_DCACHE -- requirements
Module: l1_dcache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 64, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port core  l1dcache_core_if.Server  -  responder end: en, enW, addr[29:0] word address, mask[3:0], reqData[31:0] in; respData[31:0], nack out.
REQ-006 SHALL have port memReq  output  1  backing-memory request, held until memAck.
REQ-007 SHALL have port memWe  output  1  1 = write beat, 0 = read beat.
REQ-008 SHALL have port memAddr  output  30  word address of current beat.
REQ-009 SHALL have port memMask  output  4  byte enables for a write beat.
REQ-010 SHALL have port memWData  output  32  write beat data.
REQ-011 SHALL have port memAck  input  1  beat complete this cycle.
REQ-012 SHALL have port memRData  input  32  read data, valid when memAck=1.

Function
REQ-013 SHALL split addr as offset = low log2(LINE_WORDS) bits, index = next log2(NUM_LINES) bits, tag = remaining bits.
REQ-014 SHALL implement FSM states IDLE, REFILL, WRITE; requests are accepted only in IDLE.
REQ-015 SHALL register respData and nack: a request sampled at edge N gets its response visible after edge N+1 (1-cycle latency).
REQ-016 SHALL, for en=0, drive nack=0 next cycle, hold respData, change no state; enW with en=0 is ignored.
REQ-017 SHALL, on an IDLE load hit (valid and tag match), return the addressed word on respData with nack=0.
REQ-018 SHALL, on an IDLE load miss, drive nack=1, latch the line base address, invalidate the line, and enter REFILL.
REQ-019 SHALL, in REFILL, issue LINE_WORDS read beats at offsets 0..LINE_WORDS-1 in order, advancing one beat per memAck and writing memRData into the line.
REQ-020 SHALL, on memAck of the final REFILL beat, write the tag, set the valid bit, and enter IDLE the following cycle.
REQ-021 SHALL, on an IDLE store with mask!=0, drive nack=0, merge reqData bytes under mask into the line if it hits (no allocate on miss), latch addr/mask/data, and enter WRITE.
REQ-022 SHALL, in WRITE, hold memReq=1, memWe=1 with the latched beat until memAck, then enter IDLE.
REQ-023 SHALL treat an IDLE store with mask=0 as a no-op with nack=0.
REQ-024 SHALL answer any en=1 request sampled outside IDLE, including the final-ack cycle, with nack=1 and no side effects.
REQ-025 SHALL keep memReq=0 in IDLE and keep memAddr/memWe/memMask/memWData stable while memReq=1 and memAck=0.

Reset
REQ-026 SHALL on rst force state IDLE, clear all valid bits, and set memReq=0, nack=0, respData=0, beat counter=0.
REQ-027 SHALL on rst mid-REFILL or mid-WRITE abandon the transfer: memReq=0 next cycle, line left invalid, and any memAck that cycle ignored.

Configuration
REQ-028 SHALL, with L1DCACHE_PERF_EN defined, add outputs hitCnt[31:0] and missCnt[31:0], reset to 0, counting accepted IDLE loads by hit/miss and wrapping at 2^32.
REQ-029 SHALL, without L1DCACHE_PERF_EN, omit the counter ports and logic with otherwise identical behaviour.

Structure
REQ-030 SHALL place the FSM state enum and memory-bus beat typedef in shared package Cache.
REQ-031 SHALL put tag/data storage in sub-module dcache_data_ram (one read port, one byte-masked write port, combinational read).

Verification
REQ-032 SHALL check: after reset, load addr 0x10 -> nack=1, 4 read beats at 0x10..0x13; replayed load -> nack=0, respData = beat-0 data.
REQ-033 SHALL check: with line 0x10 cached, store 0xAABBCCDD, mask 0b0100, to 0x11 -> nack=0, one write beat with mask 0b0100; reload 0x11 shows byte 2 = 0xBB, other bytes unchanged.
REQ-034 SHALL check: store to uncached 0x200 -> write beat issued, no refill; later load 0x200 misses.
REQ-035 SHALL check: a load issued during REFILL and on the final-ack cycle -> nack=1 both times; memAddr stays stable under 3-cycle memAck stalls.
REQ-036 SHALL check: rst asserted after beat 2 of a refill -> memReq=0 next cycle; reload of the same address misses again.
REQ-037 SHALL check with L1DCACHE_PERF_EN: 1 miss, 3 hits -> missCnt=1, hitCnt=3; rst -> both 0.
